ieu_id_pipe: RTL and testbench
==============================

# ieu_id_pipe

Registered, parametrised decode stage for the integer execution unit. It sits between the reservation-station issue port and the IEU execute stage. It decodes RV32I/RV64I integer, branch and jump instructions into ALU controls, operands and immediates, and flags illegal encodings. A 2-entry skid buffer gives a full-throughput valid/ready handshake on both sides, and the stage supports pipeline flush.

## Interface
- DATA_WIDTH, 32, operand/result width; legal values 32 or 64.
- ADDR_WIDTH, 32, instruction address width; must be ≤ DATA_WIDTH.
- TAG_WIDTH, 6, ROB tag width.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount width; derived, not overridable.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_flush  in  1  discard all held and incoming instructions.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept an instruction this cycle.
- i_opcode  in  7  instruction opcode.
- i_insn  in  32  raw instruction.
- i_iaddr  in  ADDR_WIDTH  instruction address.
- i_src_a, i_src_b  in  DATA_WIDTH  register operands.
- i_tag  in  TAG_WIDTH  ROB tag.
- o_valid  out  1  decoded instruction valid.
- i_ready  in  1  execute stage accepts this cycle.
- o_alu_func  out  procyon_alu_func_t  ALU operation.
- o_src_a, o_src_b  out  DATA_WIDTH  ALU operands.
- o_iaddr  out  ADDR_WIDTH  passthrough address.
- o_imm_b  out  DATA_WIDTH  sign-extended B-type immediate.
- o_shamt  out  SHAMT_WIDTH  shift amount.
- o_tag  out  TAG_WIDTH  passthrough tag.
- o_jmp, o_br  out  1  jump or conditional-branch flag.
- o_illegal  out  1  illegal encoding; all other decoded controls are forced safe.

## Operation
- Input accepted when i_valid && o_ready && !i_flush. Output transferred when o_valid && i_ready.
- Decode is combinational on the input side. Decoded results are written into the main register (MR) or the skid register (SR). Outputs are driven from MR only.
- Immediates are sign-extended from insn[31] to DATA_WIDTH:
  - I-type: insn[31:20].
  - B-type: {insn[31], insn[7], insn[30:25], insn[11:8], 0}.
  - U-type: {insn[31:12], 12'b0}.
  - J-type: {insn[31], insn[19:12], insn[20], insn[30:21], 0}.
- OP-IMM (funct3 000–111): ADD, SLL, LT, LTU, XOR, SRL/SRA, OR, AND.
  - src_b = imm_i.
  - shamt = insn[20 +: SHAMT_WIDTH].
  - SRA is selected when insn[30]=1.
- OP (funct3 000–111): ADD/SUB, SLL, LT, LTU, XOR, SRL/SRA, OR, AND.
  - SUB or SRA is selected when insn[30]=1.
  - src_b = i_src_b.
  - shamt = i_src_b[SHAMT_WIDTH-1:0].
- BRANCH: funct3 000/001/100/101/110/111 map to EQ, NE, LT, GE, LTU, GEU. Sets br=1.
- LUI: src_a=0, src_b=imm_u.
- AUIPC: src_a = zero-extended iaddr, src_b=imm_u.
- JAL: src_a=iaddr, src_b=imm_j, jmp=1.
- JALR: src_a=src_a, src_b=imm_i, jmp=1. ALU function is ADD for all four.
- Illegal (o_illegal=1) when any of the following holds:
  - opcode not in the set above;
  - BRANCH funct3 is 010 or 011;
  - JALR funct3 ≠ 000;
  - OP funct7 is neither 0000000 nor 0100000;
  - OP funct7 = 0100000 with funct3 ∉ {000, 101};
  - OP-IMM SLL/SRL/SRA with insn[31:20+SHAMT_WIDTH] other than all zero (bit 30 is allowed only for SRA);
  - DATA_WIDTH=32 and OP-IMM shift with insn[25]=1.
- Illegal entries still carry tag/iaddr and are delivered with o_valid=1. They have alu_func=ADD, src_a=src_b=0, jmp=br=0.

## Timing
- Reset (rst=1 at a clock edge):
  - MR and SR valid cleared; o_valid=0 and o_ready=1 on the following cycle.
  - All data outputs reset to 0; o_alu_func resets to ADD.
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Throughput is 1 per cycle while i_ready=1.
- o_ready = !SR.valid. It is a registered signal with no combinational path from i_ready.
- Per-edge update rules:
  - Transfer, or MR empty: MR ← SR if SR valid, else the accepted input. SR ← the accepted input if SR was valid.
  - MR holding (valid, !i_ready) and an input is accepted: input goes to SR, o_ready drops the next cycle.
  - SR full and i_ready=1: MR ← SR, SR ← new input if accepted, else SR empties.
- Output stability: while o_valid && !i_ready, all outputs hold constant.
- i_flush at an edge clears MR.valid and SR.valid. The same-cycle input is dropped and any same-cycle transfer is ignored.
- Flush has priority over accept but not over rst.
- Ordering is strictly FIFO; no instruction is dropped or duplicated except on flush.

## Test plan
- Reset, then ADDI x, 0x7FF with src_a=5 and i_ready=1 -> next cycle o_valid=1, alu=ADD, src_b=0x000007FF, o_ready=1.
- Back-to-back stream, with i_ready low for 2 cycles: SUB, SRAI by 3, BEQ with imm=-8 (i_valid held high) -> o_ready falls after the second accept. Outputs hold SUB. Order is SUB, SRAI (shamt=3), BEQ (br=1, o_imm_b=0xFFFFFFF8). No loss.
- JAL with imm=+2048 at iaddr 0x1000 -> jmp=1, src_a=0x1000, src_b=0x800. LUI 0xABCDE -> src_a=0, src_b=0xABCDE000.
- Illegal encodings: opcode 0x7F, BRANCH funct3=010, OP funct7=0000001, SLLI with insn[25]=1 at DATA_WIDTH=32 -> o_illegal=1, jmp=br=0, tag preserved.
- Flush with MR and SR full and a concurrent i_valid -> next cycle o_valid=0, o_ready=1, and the dropped instruction never appears.
- DATA_WIDTH=64: SLLI with shamt=40, then ADDI with imm=-1 -> o_shamt=40, o_illegal=0, src_b=0xFFFFFFFFFFFFFFFF.

Source files
------------

// File: rtl/ieu_id_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ieu_id_pipe : registered RV32I/RV64I integer decode stage, 2-entry skid  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+

package procyon_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,  ALU_SLL = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7,
        ALU_EQ  = 4'd8,  ALU_NE  = 4'd9,  ALU_LT  = 4'd10, ALU_LTU = 4'd11,
        ALU_GE  = 4'd12, ALU_GEU = 4'd13
    } procyon_alu_func_t;
endpackage

module ieu_id_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_flush,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [6:0]                        i_opcode,
    input  logic [31:0]                       i_insn,
    input  logic [ADDR_WIDTH-1:0]             i_iaddr,
    input  logic [DATA_WIDTH-1:0]             i_src_a,
    input  logic [DATA_WIDTH-1:0]             i_src_b,
    input  logic [TAG_WIDTH-1:0]              i_tag,
    output logic                              o_valid,
    input  logic                              i_ready,
    output procyon_pkg::procyon_alu_func_t    o_alu_func,
    output logic [DATA_WIDTH-1:0]             o_src_a,
    output logic [DATA_WIDTH-1:0]             o_src_b,
    output logic [ADDR_WIDTH-1:0]             o_iaddr,
    output logic [DATA_WIDTH-1:0]             o_imm_b,
    output logic [SHAMT_WIDTH-1:0]            o_shamt,
    output logic [TAG_WIDTH-1:0]              o_tag,
    output logic                              o_jmp,
    output logic                              o_br,
    output logic                              o_illegal
);
    import procyon_pkg::*;

    localparam logic [6:0]  c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  c_OPC_OP     = 7'b0110011;
    localparam logic [6:0]  c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OPC_JALR   = 7'b1100111;
    localparam logic [11:0] c_SHAMT_FIELD = 12'((1 << SHAMT_WIDTH) - 1);

    typedef struct packed {
        procyon_alu_func_t       alu;
        logic [DATA_WIDTH-1:0]   src_a;
        logic [DATA_WIDTH-1:0]   src_b;
        logic [DATA_WIDTH-1:0]   imm_b;
        logic [ADDR_WIDTH-1:0]   iaddr;
        logic [SHAMT_WIDTH-1:0]  shamt;
        logic [TAG_WIDTH-1:0]    tag;
        logic                    jmp;
        logic                    br;
        logic                    illegal;
    } dec_t;

    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_b;
    logic [DATA_WIDTH-1:0] w_imm_u;
    logic [DATA_WIDTH-1:0] w_imm_j;
    logic [DATA_WIDTH-1:0] w_iaddr_ext;
    logic [11:0]           w_shift_hi;
    logic                  w_ill;
    logic                  w_accept;
    logic                  w_unused;
    dec_t                  w_dec;

    dec_t r_mr;
    dec_t r_sr;
    logic r_mr_valid;
    logic r_sr_valid;

    assign w_f3        = i_insn[14:12];
    assign w_f7        = i_insn[31:25];
    assign w_imm_i     = DATA_WIDTH'($signed(i_insn[31:20]));
    assign w_imm_b     = DATA_WIDTH'($signed({i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0}));
    assign w_imm_u     = DATA_WIDTH'($signed({i_insn[31:12], 12'b0}));
    assign w_imm_j     = DATA_WIDTH'($signed({i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0}));
    assign w_iaddr_ext = DATA_WIDTH'(i_iaddr);
    assign w_unused    = ^i_insn[6:0];

    // Immediate-shift upper bits must be zero; bit 30 is tolerated only for SRAI.
    assign w_shift_hi = {i_insn[31], i_insn[30] & (w_f3 != 3'b101), i_insn[29:20]} & ~c_SHAMT_FIELD;

    always_comb begin
        w_ill       = 1'b0;
        w_dec       = '0;
        w_dec.alu   = ALU_ADD;
        w_dec.imm_b = w_imm_b;
        w_dec.iaddr = i_iaddr;
        w_dec.tag   = i_tag;
        case (i_opcode)
            c_OPC_OP_IMM: begin
                w_dec.src_a = i_src_a;
                w_dec.src_b = w_imm_i;
                w_dec.shamt = i_insn[20 +: SHAMT_WIDTH];
                case (w_f3)
                    3'b000:  w_dec.alu = ALU_ADD;
                    3'b001:  w_dec.alu = ALU_SLL;
                    3'b010:  w_dec.alu = ALU_LT;
                    3'b011:  w_dec.alu = ALU_LTU;
                    3'b100:  w_dec.alu = ALU_XOR;
                    3'b101:  w_dec.alu = i_insn[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  w_dec.alu = ALU_OR;
                    default: w_dec.alu = ALU_AND;
                endcase
                if ((w_f3 == 3'b001 || w_f3 == 3'b101) && (w_shift_hi != 12'd0)) begin
                    w_ill = 1'b1;
                end
            end
            c_OPC_OP: begin
                w_dec.src_a = i_src_a;
                w_dec.src_b = i_src_b;
                w_dec.shamt = i_src_b[SHAMT_WIDTH-1:0];
                case (w_f3)
                    3'b000:  w_dec.alu = w_f7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  w_dec.alu = ALU_SLL;
                    3'b010:  w_dec.alu = ALU_LT;
                    3'b011:  w_dec.alu = ALU_LTU;
                    3'b100:  w_dec.alu = ALU_XOR;
                    3'b101:  w_dec.alu = w_f7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  w_dec.alu = ALU_OR;
                    default: w_dec.alu = ALU_AND;
                endcase
                if (w_f7 == 7'b0100000) begin
                    w_ill = (w_f3 != 3'b000) && (w_f3 != 3'b101);
                end else if (w_f7 != 7'b0000000) begin
                    w_ill = 1'b1;
                end
            end
            c_OPC_BRANCH: begin
                w_dec.src_a = i_src_a;
                w_dec.src_b = i_src_b;
                w_dec.br    = 1'b1;
                case (w_f3)
                    3'b000:  w_dec.alu = ALU_EQ;
                    3'b001:  w_dec.alu = ALU_NE;
                    3'b100:  w_dec.alu = ALU_LT;
                    3'b101:  w_dec.alu = ALU_GE;
                    3'b110:  w_dec.alu = ALU_LTU;
                    3'b111:  w_dec.alu = ALU_GEU;
                    default: w_ill     = 1'b1;
                endcase
            end
            c_OPC_LUI: begin
                w_dec.src_b = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_dec.src_a = w_iaddr_ext;
                w_dec.src_b = w_imm_u;
            end
            c_OPC_JAL: begin
                w_dec.src_a = w_iaddr_ext;
                w_dec.src_b = w_imm_j;
                w_dec.jmp   = 1'b1;
            end
            c_OPC_JALR: begin
                w_dec.src_a = i_src_a;
                w_dec.src_b = w_imm_i;
                w_dec.jmp   = 1'b1;
                w_ill       = (w_f3 != 3'b000);
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal entries travel with their tag/address but carry inert controls.
        if (w_ill) begin
            w_dec.alu   = ALU_ADD;
            w_dec.src_a = '0;
            w_dec.src_b = '0;
            w_dec.imm_b = '0;
            w_dec.shamt = '0;
            w_dec.jmp   = 1'b0;
            w_dec.br    = 1'b0;
        end
        w_dec.illegal = w_ill;
    end

    assign w_accept = i_valid && !r_sr_valid && !i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mr_valid <= 1'b0;
            r_sr_valid <= 1'b0;
            r_mr       <= '0;
            r_sr       <= '0;
        end else if (i_flush) begin
            r_mr_valid <= 1'b0;
            r_sr_valid <= 1'b0;
        end else if (!r_mr_valid || i_ready) begin
            if (r_sr_valid) begin
                r_mr       <= r_sr;
                r_mr_valid <= 1'b1;
                r_sr_valid <= w_accept;
                if (w_accept) begin
                    r_sr <= w_dec;
                end
            end else begin
                r_mr_valid <= w_accept;
                if (w_accept) begin
                    r_mr <= w_dec;
                end
            end
        end else if (w_accept) begin
            r_sr       <= w_dec;
            r_sr_valid <= 1'b1;
        end
    end

    assign o_ready    = !r_sr_valid;
    assign o_valid    = r_mr_valid;
    assign o_alu_func = r_mr.alu;
    assign o_src_a    = r_mr.src_a;
    assign o_src_b    = r_mr.src_b;
    assign o_iaddr    = r_mr.iaddr;
    assign o_imm_b    = r_mr.imm_b;
    assign o_shamt    = r_mr.shamt;
    assign o_tag      = r_mr.tag;
    assign o_jmp      = r_mr.jmp;
    assign o_br       = r_mr.br;
    assign o_illegal  = r_mr.illegal;

endmodule
`default_nettype wire

// File: tb/tb_ieu_id_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ieu_id_pipe : bench for ieu_id_pipe (32-bit and 64-bit instances)     |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_ieu_id_pipe;
    import procyon_pkg::*;

    typedef struct packed {
        procyon_alu_func_t alu;
        logic [63:0] a, b, ia, immb;
        logic [5:0]  sh, tag;
        logic        jmp, br, ill;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, i_flush, i_valid, i_ready, o_ready, o_valid, o_jmp, o_br, o_illegal;
    logic [6:0] i_opcode;
    logic [31:0] i_insn, i_iaddr, i_src_a, i_src_b, o_src_a, o_src_b, o_iaddr, o_imm_b;
    logic [5:0] i_tag, o_tag;
    logic [4:0] o_shamt;
    procyon_alu_func_t o_alu_func;

    logic v_valid, u_ready, u_valid, u_jmp, u_br, u_ill;
    logic v_flush = 1'b0;
    logic v_ready = 1'b1;
    logic [6:0] v_opcode;
    logic [31:0] v_insn, v_iaddr, u_iaddr;
    logic [63:0] v_src_a, v_src_b, u_src_a, u_src_b, u_imm_b;
    logic [5:0] v_tag, u_tag, u_shamt;
    procyon_alu_func_t u_alu;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;
    exp_t exp_q[$];

    ieu_id_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) dut32 (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_insn(i_insn), .i_iaddr(i_iaddr), .i_src_a(i_src_a),
        .i_src_b(i_src_b), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
        .o_alu_func(o_alu_func), .o_src_a(o_src_a), .o_src_b(o_src_b), .o_iaddr(o_iaddr),
        .o_imm_b(o_imm_b), .o_shamt(o_shamt), .o_tag(o_tag), .o_jmp(o_jmp), .o_br(o_br),
        .o_illegal(o_illegal)
    );

    ieu_id_pipe #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TAG_WIDTH(6)) dut64 (
        .clk(clk), .rst(rst), .i_flush(v_flush), .i_valid(v_valid), .o_ready(u_ready),
        .i_opcode(v_opcode), .i_insn(v_insn), .i_iaddr(v_iaddr), .i_src_a(v_src_a),
        .i_src_b(v_src_b), .i_tag(v_tag), .o_valid(u_valid), .i_ready(v_ready),
        .o_alu_func(u_alu), .o_src_a(u_src_a), .o_src_b(u_src_b), .o_iaddr(u_iaddr),
        .o_imm_b(u_imm_b), .o_shamt(u_shamt), .o_tag(u_tag), .o_jmp(u_jmp), .o_br(u_br),
        .o_illegal(u_ill)
    );

    function automatic procyon_alu_func_t arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_LT;
            3'd3: return ALU_LTU;
            3'd4: return ALU_XOR;
            3'd5: return alt ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Reference decode straight from the ISA rules, computed in 64 bits and truncated.
    function automatic exp_t model(input int dw, input logic [6:0] opc, input logic [31:0] insn,
                                   input logic [31:0] ia, input logic [63:0] sa,
                                   input logic [63:0] sb, input logic [5:0] tag);
        exp_t e;
        logic [63:0] imm_i, imm_u, imm_j, msk;
        logic [11:0] upper;
        logic [2:0] f3;
        logic [6:0] f7;
        logic bad;
        int sw;
        sw    = (dw == 64) ? 6 : 5;
        msk   = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        imm_i = {{52{insn[31]}}, insn[31:20]};
        imm_u = {{32{insn[31]}}, insn[31:12], 12'h000};
        imm_j = {{43{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        f3 = insn[14:12];
        f7 = insn[31:25];
        e = '0;
        e.alu  = ALU_ADD;
        e.ia   = 64'(ia);
        e.tag  = tag;
        e.immb = {{51{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        bad = 1'b0;
        case (opc)
            7'h13: begin
                e.a = sa; e.b = imm_i;
                e.sh = 6'((insn >> 20) & ((32'd1 << sw) - 32'd1));
                e.alu = (f3 == 3'd0) ? ALU_ADD : arith(f3, insn[30]);
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    upper = 12'(insn[31:20] >> sw);
                    if (f3 == 3'd5) upper[10-sw] = 1'b0;
                    bad = (upper != 12'd0);
                end
            end
            7'h33: begin
                e.a = sa; e.b = sb;
                e.sh = 6'(sb & ((64'd1 << sw) - 64'd1));
                if (f7 == 7'h00) e.alu = arith(f3, 1'b0);
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.alu = arith(f3, 1'b1);
                else bad = 1'b1;
            end
            7'h63: begin
                e.a = sa; e.b = sb; e.br = 1'b1;
                case (f3)
                    3'd0: e.alu = ALU_EQ;
                    3'd1: e.alu = ALU_NE;
                    3'd4: e.alu = ALU_LT;
                    3'd5: e.alu = ALU_GE;
                    3'd6: e.alu = ALU_LTU;
                    3'd7: e.alu = ALU_GEU;
                    default: bad = 1'b1;
                endcase
            end
            7'h37: e.b = imm_u;
            7'h17: begin e.a = 64'(ia); e.b = imm_u; end
            7'h6F: begin e.a = 64'(ia); e.b = imm_j; e.jmp = 1'b1; end
            7'h67: begin e.a = sa; e.b = imm_i; e.jmp = 1'b1; bad = (f3 != 3'd0); end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            e.alu = ALU_ADD; e.a = '0; e.b = '0; e.immb = '0; e.sh = '0;
            e.jmp = 1'b0; e.br = 1'b0;
        end
        e.ill  = bad;
        e.a    = e.a & msk;
        e.b    = e.b & msk;
        e.immb = e.immb & msk;
        return e;
    endfunction

    function automatic exp_t act32();
        exp_t a;
        a.alu = o_alu_func; a.a = 64'(o_src_a); a.b = 64'(o_src_b); a.ia = 64'(o_iaddr);
        a.immb = 64'(o_imm_b); a.sh = 6'(o_shamt); a.tag = o_tag;
        a.jmp = o_jmp; a.br = o_br; a.ill = o_illegal;
        return a;
    endfunction

    function automatic exp_t act64();
        exp_t a;
        a.alu = u_alu; a.a = u_src_a; a.b = u_src_b; a.ia = 64'(u_iaddr);
        a.immb = u_imm_b; a.sh = u_shamt; a.tag = u_tag;
        a.jmp = u_jmp; a.br = u_br; a.ill = u_ill;
        return a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_dec(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got alu=%0d a=%h b=%h ia=%h immb=%h sh=%0d tag=%h j=%b br=%b ill=%b, expected alu=%0d a=%h b=%h ia=%h immb=%h sh=%0d tag=%h j=%b br=%b ill=%b",
                     name, act.alu, act.a, act.b, act.ia, act.immb, act.sh, act.tag, act.jmp, act.br, act.ill,
                     exp.alu, exp.a, exp.b, exp.ia, exp.immb, exp.sh, exp.tag, exp.jmp, exp.br, exp.ill);
        end
    endtask

    // Compare process: at each negedge check the held contents, then apply the coming edge.
    always @(negedge clk) begin
        int  sz;
        bit  can_acc;
        if (mon_en) begin
            sz = exp_q.size();
            chk("o_valid", 64'(o_valid), 64'(sz != 0));
            chk("o_ready", 64'(o_ready), 64'(sz < 2));
            if (sz != 0) cmp_dec("out32", act32(), exp_q[0]);
            if (rst || i_flush) begin
                exp_q.delete();
            end else begin
                can_acc = (sz < 2);
                if (sz != 0 && i_ready) void'(exp_q.pop_front());
                if (i_valid && can_acc)
                    exp_q.push_back(model(32, i_opcode, i_insn, i_iaddr, 64'(i_src_a), 64'(i_src_b), i_tag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] opc, input logic [31:0] insn, input logic [31:0] ia,
                          input logic [31:0] sa, input logic [31:0] sb, input logic [5:0] tag);
        i_opcode = opc; i_insn = insn; i_iaddr = ia; i_src_a = sa; i_src_b = sb; i_tag = tag;
        i_valid = 1'b1;
    endtask

    task automatic drain();
        i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!o_valid) break;
        end
        chk("drain_empty", 64'(o_valid), 64'd0);
        tick();
    endtask

    task automatic rand_insn();
        logic [6:0] opcs [7];
        logic [6:0] opc;
        logic [31:0] insn;
        opcs[0] = 7'h13; opcs[1] = 7'h33; opcs[2] = 7'h63; opcs[3] = 7'h37;
        opcs[4] = 7'h17; opcs[5] = 7'h6F; opcs[6] = 7'h67;
        opc  = ($urandom_range(0, 15) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 6)];
        insn = $urandom;
        insn[6:0] = opc;
        if (opc == 7'h33 && $urandom_range(0, 4) != 0)
            insn[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        if (opc == 7'h13 && (insn[14:12] == 3'd1 || insn[14:12] == 3'd5) && $urandom_range(0, 3) != 0) begin
            insn[31:25] = 7'h00;
            if (insn[14:12] == 3'd5) insn[30] = 1'($urandom_range(0, 1));
        end
        if (opc == 7'h67 && $urandom_range(0, 3) != 0) insn[14:12] = 3'd0;
        set_in(opc, insn, $urandom, $urandom, $urandom, 6'($urandom));
        i_valid = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic [31:0] ill_insn [4];
        logic [5:0]  ill_tag  [4];

        rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        set_in(7'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6'h0);
        i_valid = 1'b0;
        v_valid = 1'b0; v_opcode = '0; v_insn = '0; v_iaddr = '0; v_src_a = '0; v_src_b = '0; v_tag = '0;

        // Model pins against hand-decoded encodings.
        e = model(32, 7'h63, 32'hFE000CE3, 32'h0, 64'h0, 64'h0, 6'h0);
        chk("model_beq_immb", e.immb, 64'h0000_0000_FFFF_FFF8);
        e = model(32, 7'h6F, 32'h0010006F, 32'h1000, 64'h0, 64'h0, 6'h0);
        chk("model_jal_b", e.b, 64'h800);
        e = model(64, 7'h13, 32'hFFF00013, 32'h0, 64'h0, 64'h0, 6'h0);
        chk("model_addi64_b", e.b, 64'hFFFF_FFFF_FFFF_FFFF);
        e = model(32, 7'h13, 32'h02001013, 32'h0, 64'h0, 64'h0, 6'h0);
        chk("model_slli32_ill", 64'(e.ill), 64'd1);

        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_ready", 64'(o_ready), 64'd1);
        chk("rst_o_alu", 64'(o_alu_func), 64'(ALU_ADD));
        chk("rst_o_src_a", 64'(o_src_a), 64'd0);
        chk("rst_o_src_b", 64'(o_src_b), 64'd0);
        chk("rst_o_tag", 64'(o_tag), 64'd0);
        mon_en = 1'b1;
        tick();

        // ADDI imm 0x7FF
        set_in(7'h13, 32'h7FF00093, 32'h100, 32'd5, 32'h1234, 6'd1);
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        chk("addi_valid", 64'(o_valid), 64'd1);
        chk("addi_alu", 64'(o_alu_func), 64'(ALU_ADD));
        chk("addi_src_a", 64'(o_src_a), 64'd5);
        chk("addi_src_b", 64'(o_src_b), 64'h7FF);
        chk("addi_ready", 64'(o_ready), 64'd1);
        tick();

        // SUB, SRAI 3, BEQ -8 with i_ready low for two edges
        i_ready = 1'b0;
        set_in(7'h33, 32'h40000033, 32'h200, 32'd10, 32'd3, 6'd2);
        tick();
        set_in(7'h13, 32'h40305013, 32'h204, 32'hFFFFFF00, 32'd0, 6'd3);
        tick();
        set_in(7'h63, 32'hFE000CE3, 32'h208, 32'd7, 32'd7, 6'd4);
        i_ready = 1'b1;
        @(negedge clk);
        chk("stall_ready_low", 64'(o_ready), 64'd0);
        chk("stall_hold_alu", 64'(o_alu_func), 64'(ALU_SUB));
        chk("stall_hold_tag", 64'(o_tag), 64'd2);
        tick();
        @(negedge clk);
        chk("srai_alu", 64'(o_alu_func), 64'(ALU_SRA));
        chk("srai_shamt", 64'(o_shamt), 64'd3);
        chk("srai_ready", 64'(o_ready), 64'd1);
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        chk("beq_br", 64'(o_br), 64'd1);
        chk("beq_immb", 64'(o_imm_b), 64'hFFFF_FFF8);
        chk("beq_alu", 64'(o_alu_func), 64'(ALU_EQ));
        tick();

        // JAL +2048, then LUI 0xABCDE
        set_in(7'h6F, 32'h0010006F, 32'h1000, 32'h55, 32'h66, 6'd5);
        tick();
        set_in(7'h37, 32'hABCDE037, 32'h1004, 32'h77, 32'h88, 6'd6);
        @(negedge clk);
        chk("jal_jmp", 64'(o_jmp), 64'd1);
        chk("jal_src_a", 64'(o_src_a), 64'h1000);
        chk("jal_src_b", 64'(o_src_b), 64'h800);
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        chk("lui_src_a", 64'(o_src_a), 64'd0);
        chk("lui_src_b", 64'(o_src_b), 64'hABCDE000);
        tick();

        // Illegal encodings
        ill_insn[0] = 32'h0000007F; ill_tag[0] = 6'h11;
        ill_insn[1] = 32'h00002063; ill_tag[1] = 6'h12;
        ill_insn[2] = 32'h02000033; ill_tag[2] = 6'h13;
        ill_insn[3] = 32'h02001013; ill_tag[3] = 6'h14;
        for (int k = 0; k < 4; k++) begin
            set_in(ill_insn[k][6:0], ill_insn[k], 32'h3000, 32'hDEAD, 32'hBEEF, ill_tag[k]);
            tick();
            i_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("ill%0d_flag", k), 64'(o_illegal), 64'd1);
            chk($sformatf("ill%0d_jmpbr", k), 64'({o_jmp, o_br}), 64'd0);
            chk($sformatf("ill%0d_tag", k), 64'(o_tag), 64'(ill_tag[k]));
            chk($sformatf("ill%0d_src_a", k), 64'(o_src_a), 64'd0);
            tick();
        end

        // Flush with MR and SR full plus a concurrent input
        i_ready = 1'b0;
        set_in(7'h13, 32'h00100093, 32'h400, 32'd1, 32'd0, 6'h21);
        tick();
        set_in(7'h13, 32'h00200093, 32'h404, 32'd2, 32'd0, 6'h22);
        tick();
        set_in(7'h13, 32'h00300093, 32'h408, 32'd3, 32'd0, 6'h3F);
        i_flush = 1'b1;
        @(negedge clk);
        chk("preflush_ready", 64'(o_ready), 64'd0);
        tick();
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", 64'(o_valid), 64'd0);
        chk("flush_ready", 64'(o_ready), 64'd1);
        tick();
        // Flush while empty with a valid input: it must be dropped
        set_in(7'h13, 32'h00400093, 32'h40C, 32'd4, 32'd0, 6'h3E);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        chk("flush_drop_valid", 64'(o_valid), 64'd0);
        tick();

        // DATA_WIDTH=64: SLLI 40, ADDI -1, SLLI with bit 26 set
        v_opcode = 7'h13; v_insn = 32'h02801013; v_iaddr = 32'h500; v_src_a = 64'h1; v_tag = 6'd7;
        v_valid = 1'b1;
        tick();
        v_insn = 32'hFFF00013; v_tag = 6'd8;
        @(negedge clk);
        chk("d64_slli_shamt", 64'(u_shamt), 64'd40);
        chk("d64_slli_ill", 64'(u_ill), 64'd0);
        chk("d64_slli_alu", 64'(u_alu), 64'(ALU_SLL));
        cmp_dec("d64_slli", act64(), model(64, 7'h13, 32'h02801013, 32'h500, 64'h1, 64'h0, 6'd7));
        tick();
        v_insn = 32'h04001013; v_tag = 6'd9;
        @(negedge clk);
        chk("d64_addi_b", u_src_b, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("d64_addi_ill", 64'(u_ill), 64'd0);
        tick();
        v_valid = 1'b0;
        @(negedge clk);
        chk("d64_bit26_ill", 64'(u_ill), 64'd1);
        chk("d64_bit26_tag", 64'(u_tag), 64'd9);
        tick();

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 4000; c++) begin
            rand_insn();
            i_ready = ($urandom_range(0, 3) != 0);
            i_flush = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        drain();
        chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
